// File: rtl/gb_cpu_mcycle_sequencer_if.sv
// Decoder/datapath <-> M-cycle sequencer signal bundle.
interface gb_cpu_mcycle_sequencer_if #(
  parameter int MAX_MCYCLES = 6,
  parameter int CTRL_W      = 16,
  parameter int T_PER_M     = 4
);
  localparam int MW = $clog2(MAX_MCYCLES);
  localparam int LW = $clog2(MAX_MCYCLES + 1);
  localparam int TW = $clog2(T_PER_M);

  logic                          ir_valid;
  logic [7:0]                    opcode;
  logic [MAX_MCYCLES*CTRL_W-1:0] sched_ctrl;
  logic [LW-1:0]                 sched_len;
  logic                          sched_is_cond;
  logic [MW-1:0]                 sched_cond_idx;
  logic                          cond_met;
  logic                          stall;

  logic [CTRL_W-1:0]             ctrl;
  logic                          ctrl_valid;
  logic [MW-1:0]                 m_cycle;
  logic [TW-1:0]                 t_cycle;
  logic                          cb_prefix;
  logic                          fetch_req;
  logic                          protocol_err;

  modport master (
    output ir_valid, opcode, sched_ctrl, sched_len,
    output sched_is_cond, sched_cond_idx, cond_met, stall,
    input  ctrl, ctrl_valid, m_cycle, t_cycle,
    input  cb_prefix, fetch_req, protocol_err
  );

  modport slave (
    input  ir_valid, opcode, sched_ctrl, sched_len,
    input  sched_is_cond, sched_cond_idx, cond_met, stall,
    output ctrl, ctrl_valid, m_cycle, t_cycle,
    output cb_prefix, fetch_req, protocol_err
  );
endinterface

// File: rtl/gb_cpu_mcycle_sequencer.sv
// Steps a latched per-M-cycle control schedule, T_PER_M clocks per M-cycle,
// with CB-prefix tracking, early exit on failed conditions and stalls.
module gb_cpu_mcycle_sequencer #(
  parameter int MAX_MCYCLES = 6,
  parameter int CTRL_W      = 16,
  parameter int T_PER_M     = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  gb_cpu_mcycle_sequencer_if.slave  bus
);
  localparam int MW = $clog2(MAX_MCYCLES);
  localparam int LW = $clog2(MAX_MCYCLES + 1);
  localparam int TW = $clog2(T_PER_M);
  localparam int SW = MAX_MCYCLES * CTRL_W;
  localparam logic [TW-1:0] T_LAST = TW'(T_PER_M - 1);
  localparam logic [LW-1:0] L_MAX  = LW'(MAX_MCYCLES);

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t            r_state;
  logic [SW-1:0]     r_sched;
  logic [LW-1:0]     r_len;
  logic              r_is_cond;
  logic [MW-1:0]     r_cond_idx;
  logic [MW-1:0]     r_m;
  logic [TW-1:0]     r_t;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_cb;
  logic              r_prefix;
  logic              r_err;

  logic [LW-1:0]     w_len;
  logic              w_new_prefix;
  logic              w_t_end;
  logic              w_last;
  logic              w_end;
  logic [MW-1:0]     w_m_nxt;
  logic [CTRL_W-1:0] w_word_nxt;

  always_comb begin
    w_len = bus.sched_len;
    if (bus.sched_len == '0)
      w_len = LW'(1);
    else if (bus.sched_len > L_MAX)
      w_len = L_MAX;
  end

  // A CB seen while already prefixed is a real CB-table opcode.
  assign w_new_prefix = (bus.opcode == 8'hCB) && !r_cb;
  assign w_t_end      = (r_t == T_LAST);
  assign w_last       = (LW'(r_m) == r_len - LW'(1)) ||
                        (r_is_cond && (r_m == r_cond_idx) && !bus.cond_met);
  assign w_end        = (r_state == S_EXEC) && !bus.stall &&
                        w_t_end && w_last;
  assign w_m_nxt      = r_m + MW'(1);
  assign w_word_nxt   = CTRL_W'(r_sched >> (CTRL_W * int'(w_m_nxt)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_sched    <= '0;
      r_len      <= '0;
      r_is_cond  <= 1'b0;
      r_cond_idx <= '0;
      r_m        <= '0;
      r_t        <= '0;
      r_ctrl     <= '0;
      r_cb       <= 1'b0;
      r_prefix   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.ir_valid) begin
            r_state <= S_EXEC;
            r_m     <= '0;
            r_t     <= '0;
            if (w_new_prefix) begin
              r_prefix   <= 1'b1;
              r_sched    <= '0;
              r_len      <= LW'(1);
              r_is_cond  <= 1'b0;
              r_cond_idx <= '0;
              r_ctrl     <= '0;
            end else begin
              r_prefix   <= 1'b0;
              r_sched    <= bus.sched_ctrl;
              r_len      <= w_len;
              r_is_cond  <= bus.sched_is_cond;
              r_cond_idx <= bus.sched_cond_idx;
              r_ctrl     <= bus.sched_ctrl[CTRL_W-1:0];
            end
          end
        end
        S_EXEC: begin
          if (bus.ir_valid)
            r_err <= 1'b1;
          if (!bus.stall) begin
            if (!w_t_end) begin
              r_t <= r_t + TW'(1);
            end else if (w_last) begin
              r_state <= S_IDLE;
              r_t     <= '0;
              r_m     <= '0;
              r_ctrl  <= '0;
              r_cb    <= r_prefix;
            end else begin
              r_t    <= '0;
              r_m    <= w_m_nxt;
              r_ctrl <= w_word_nxt;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ctrl         = r_ctrl;
  assign bus.ctrl_valid   = (r_state == S_EXEC);
  assign bus.m_cycle      = r_m;
  assign bus.t_cycle      = r_t;
  assign bus.cb_prefix    = r_cb;
  assign bus.fetch_req    = w_end;
  assign bus.protocol_err = r_err;
endmodule

// File: tb/tb_gb_cpu_mcycle_sequencer.sv
// Scoreboard bench for gb_cpu_mcycle_sequencer: per-clock expected
// output records are queued at issue time and compared as they occur.
module tb_gb_cpu_mcycle_sequencer;
  localparam int MAXM = 6;
  localparam int CW   = 16;
  localparam int TPM  = 4;

  typedef struct packed {
    logic [15:0] c;
    logic        v;
    logic [2:0]  m;
    logic [1:0]  t;
    logic        f;
    logic        cb;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic st;
    logic iv;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gb_cpu_mcycle_sequencer_if #(
    .MAX_MCYCLES(MAXM), .CTRL_W(CW), .T_PER_M(TPM)
  ) bus ();

  gb_cpu_mcycle_sequencer #(
    .MAX_MCYCLES(MAXM), .CTRL_W(CW), .T_PER_M(TPM)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  exp_t  eq[$];
  stim_t sq[$];
  bit    cb_m;
  bit    err_m;
  int    checks = 0;
  int    passed = 0;

  function automatic exp_t observe();
    return {bus.ctrl, bus.ctrl_valid, bus.m_cycle, bus.t_cycle,
            bus.fetch_req, bus.cb_prefix, bus.protocol_err};
  endfunction

  // Drive one opcode and queue the expected per-clock outputs.
  task automatic issue(input bit wt, input logic [7:0] op,
                       input logic [95:0] w, input int len,
                       input bit cnd, input int cidx, input bit met,
                       input int sm, input int st, input int sn,
                       input int ivm, input int ivt);
    bit    pf;
    int    l;
    int    last;
    exp_t  e;
    stim_t s;
    if (wt) @(negedge clk);
    bus.ir_valid       = 1'b1;
    bus.opcode         = op;
    bus.sched_ctrl     = w;
    bus.sched_len      = 3'(len);
    bus.sched_is_cond  = cnd;
    bus.sched_cond_idx = 3'(cidx);
    bus.cond_met       = met;
    bus.stall          = 1'b0;
    pf   = (op == 8'hCB) && !cb_m;
    l    = (len == 0) ? 1 : ((len > MAXM) ? MAXM : len);
    last = (cnd && cidx < l && !met) ? cidx : l - 1;
    if (pf) last = 0;
    for (int m = 0; m <= last; m++) begin
      for (int t = 0; t < TPM; t++) begin
        e.c   = pf ? 16'h0 : w[m*CW +: CW];
        e.v   = 1'b1;
        e.m   = 3'(m);
        e.t   = 2'(t);
        e.cb  = cb_m;
        e.err = err_m;
        e.f   = 1'b0;
        if (m == sm && t == st) begin
          for (int k = 0; k < sn; k++) begin
            eq.push_back(e);
            s = '{st: 1'b1, iv: 1'b0};
            sq.push_back(s);
          end
        end
        e.f = (t == TPM - 1) && (m == last);
        eq.push_back(e);
        s = '{st: 1'b0, iv: (m == ivm && t == ivt)};
        sq.push_back(s);
        if (m == ivm && t == ivt) err_m = 1'b1;
      end
    end
    cb_m = pf;
    e = '{c: 16'h0, v: 1'b0, m: 3'd0, t: 2'd0, f: 1'b0,
          cb: cb_m, err: err_m};
    eq.push_back(e);
    s = '{st: 1'b0, iv: 1'b0};
    sq.push_back(s);
  endtask

  task automatic test_reset();
    exp_t o;
    bus.ir_valid = 0; bus.opcode = 0; bus.sched_ctrl = '0;
    bus.sched_len = 0; bus.sched_is_cond = 0;
    bus.sched_cond_idx = 0; bus.cond_met = 0; bus.stall = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    o = observe();
    checks++;
    if (o !== 25'h0)
      $display("FAIL reset: got %h want %h", o, 25'h0);
    else passed++;
    rst = 1'b0;
    cb_m = 0; err_m = 0;
  endtask

  task automatic test_single();
    exp_t e, o; stim_t s;
    issue(1, 8'h80, {80'h0, 16'h1234}, 1, 0, 0, 0, -1, 0, 0, -1, 0);
    while (eq.size() > 0) begin
      @(negedge clk);
      s = sq.pop_front(); bus.ir_valid = s.iv; bus.stall = s.st;
      #1; e = eq.pop_front(); o = observe(); checks++;
      if (o !== e) $display("FAIL single: got %h want %h", o, e);
      else passed++;
    end
  endtask

  task automatic test_multi();
    exp_t e, o; stim_t s;
    issue(1, 8'h01, {48'h0, 16'hA003, 16'hA002, 16'hA001},
          3, 0, 0, 0, -1, 0, 0, -1, 0);
    while (eq.size() > 0) begin
      @(negedge clk);
      s = sq.pop_front(); bus.ir_valid = s.iv; bus.stall = s.st;
      #1; e = eq.pop_front(); o = observe(); checks++;
      if (o !== e) $display("FAIL multi: got %h want %h", o, e);
      else passed++;
    end
  endtask

  task automatic test_cond();
    exp_t e, o; stim_t s;
    int cidx_t[3] = '{1, 1, 5};
    bit met_t[3]  = '{0, 1, 0};
    for (int k = 0; k < 3; k++) begin
      issue(1, 8'hC2, {48'h0, 16'hA003, 16'hA002, 16'hA001},
            3, 1, cidx_t[k], met_t[k], -1, 0, 0, -1, 0);
      while (eq.size() > 0) begin
        @(negedge clk);
        s = sq.pop_front(); bus.ir_valid = s.iv; bus.stall = s.st;
        #1; e = eq.pop_front(); o = observe(); checks++;
        if (o !== e) $display("FAIL cond%0d: got %h want %h", k, o, e);
        else passed++;
      end
    end
  endtask

  task automatic test_clamp();
    exp_t e, o; stim_t s;
    int len_t[2] = '{0, 7};
    for (int k = 0; k < 2; k++) begin
      issue(1, 8'h10, {16'hC006, 16'hC005, 16'hC004,
                       16'hC003, 16'hC002, 16'hC001},
            len_t[k], 0, 0, 0, -1, 0, 0, -1, 0);
      while (eq.size() > 0) begin
        @(negedge clk);
        s = sq.pop_front(); bus.ir_valid = s.iv; bus.stall = s.st;
        #1; e = eq.pop_front(); o = observe(); checks++;
        if (o !== e) $display("FAIL clamp%0d: got %h want %h", k, o, e);
        else passed++;
      end
    end
  endtask

  task automatic test_prefix();
    exp_t e, o; stim_t s;
    logic [7:0] op_t[4] = '{8'hCB, 8'h37, 8'hCB, 8'hCB};
    int len_t[4]        = '{3, 2, 2, 1};
    for (int k = 0; k < 4; k++) begin
      issue(1, op_t[k], {48'h0, 16'hD003, 16'hD002, 16'hD001},
            len_t[k], 0, 0, 0, -1, 0, 0, -1, 0);
      while (eq.size() > 0) begin
        @(negedge clk);
        s = sq.pop_front(); bus.ir_valid = s.iv; bus.stall = s.st;
        #1; e = eq.pop_front(); o = observe(); checks++;
        if (o !== e) $display("FAIL prefix%0d: got %h want %h", k, o, e);
        else passed++;
      end
    end
  endtask

  task automatic test_stall();
    exp_t e, o; stim_t s;
    issue(1, 8'h22, {64'h0, 16'hB002, 16'hB001},
          2, 0, 0, 0, 1, 1, 3, -1, 0);
    while (eq.size() > 0) begin
      @(negedge clk);
      s = sq.pop_front(); bus.ir_valid = s.iv; bus.stall = s.st;
      #1; e = eq.pop_front(); o = observe(); checks++;
      if (o !== e) $display("FAIL stall: got %h want %h", o, e);
      else passed++;
    end
    bus.stall = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e, o; stim_t s;
    for (int k = 0; k < 3; k++) begin
      issue(k == 0, 8'(8'h40 + k), {64'h0, 16'(16'hE100 + k), 16'(16'hE000 + k)},
            1 + k, 0, 0, 0, -1, 0, 0, -1, 0);
      while (eq.size() > 0) begin
        @(negedge clk);
        s = sq.pop_front(); bus.ir_valid = s.iv; bus.stall = s.st;
        #1; e = eq.pop_front(); o = observe(); checks++;
        if (o !== e) $display("FAIL b2b%0d: got %h want %h", k, o, e);
        else passed++;
      end
    end
  endtask

  task automatic test_protocol_err();
    exp_t e, o; stim_t s;
    issue(1, 8'h05, {48'h0, 16'hF003, 16'hF002, 16'hF001},
          3, 0, 0, 0, -1, 0, 0, 1, 2);
    while (eq.size() > 0) begin
      @(negedge clk);
      s = sq.pop_front(); bus.ir_valid = s.iv; bus.stall = s.st;
      if (s.iv) begin
        bus.opcode = 8'h00; bus.sched_ctrl = '1; bus.sched_len = 3'd1;
      end
      #1; e = eq.pop_front(); o = observe(); checks++;
      if (o !== e) $display("FAIL proterr: got %h want %h", o, e);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, o; stim_t s;
    issue(1, 8'hCB, '0, 1, 0, 0, 0, -1, 0, 0, -1, 0);
    while (eq.size() > 0) begin
      @(negedge clk);
      s = sq.pop_front(); bus.ir_valid = s.iv; bus.stall = s.st;
      #1; e = eq.pop_front(); o = observe(); checks++;
      if (o !== e) $display("FAIL rstmid_pre: got %h want %h", o, e);
      else passed++;
    end
    issue(1, 8'h66, {48'h0, 16'h9003, 16'h9002, 16'h9001},
          3, 0, 0, 0, -1, 0, 0, -1, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s = sq.pop_front(); bus.ir_valid = s.iv; bus.stall = s.st;
      #1; e = eq.pop_front(); o = observe(); checks++;
      if (o !== e) $display("FAIL rstmid_run: got %h want %h", o, e);
      else passed++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    o = observe(); checks++;
    if (o !== 25'h0) $display("FAIL rstmid: got %h want %h", o, 25'h0);
    else passed++;
    rst = 1'b0;
    eq.delete(); sq.delete();
    cb_m = 0; err_m = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_cond();
    test_clamp();
    test_prefix();
    test_stall();
    test_back_to_back();
    test_protocol_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
